ex_multdiv_unit: RTL and testbench

EX_MULTDIV_UNIT -- requirements
Module: ex_multdiv_unit

---
 rtl/ex_multdiv_unit.sv | 143 ++++++++++++++
 tb/tb_ex_multdiv_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ex_multdiv_unit.sv
// Iterative EX-stage multiply/divide unit with HI/LO registers.
// One multiply (shift-add) or divide (restoring) iteration per cycle, 33-cycle fixed latency.
module ex_multdiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        hilo_rd,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        stall_req,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] p_q, p_d;      // mult: {acc, multiplier}; div: {remainder, quotient}
  logic [31:0] b_q, b_d;      // multiplicand or divisor magnitude
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;

  logic        is_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_shift, rem_diff;
  logic [63:0] div_next;
  logic [63:0] prod_fix;

  assign is_signed = ~op[0];
  assign abs_a = (is_signed && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
  assign abs_b = (is_signed && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;

  assign mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_next = {mul_sum, p_q[31:1]};

  // The shifted remainder is below twice the divisor, so 33 bits hold it and the difference fits 32.
  assign rem_shift = p_q[63:31];
  assign rem_diff  = rem_shift - {1'b0, b_q};
  assign div_next  = rem_diff[32] ? {rem_shift[31:0], p_q[30:0], 1'b0}
                                  : {rem_diff[31:0],  p_q[30:0], 1'b1};

  assign prod_fix = neg_q ? (~p_q + 64'd1) : p_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op[1] && (rt_val == 32'd0)) begin
            hi_d   = rs_val;
            lo_d   = 32'hFFFF_FFFF;
            done_d = 1'b1;
          end else begin
            is_div_d = op[1];
            neg_d    = is_signed & (rs_val[31] ^ rt_val[31]);
            rneg_d   = is_signed & rs_val[31];
            b_d      = op[1] ? abs_b : abs_a;
            p_d      = {32'd0, op[1] ? abs_a : abs_b};
            cnt_d    = 6'd0;
            state_d  = S_RUN;
          end
        end else begin
          if (mthi) hi_d = rs_val;
          if (mtlo) lo_d = rs_val;
        end
      end
      S_RUN: begin
        p_d   = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rneg_q ? (~p_q[63:32] + 32'd1) : p_q[63:32];
          lo_d = neg_q  ? (~p_q[31:0] + 32'd1)  : p_q[31:0];
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers are cleared as well so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      p_q      <= 64'd0;
      b_q      <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign stall_req = busy & (start | mthi | mtlo | hilo_rd);
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ex_multdiv_unit.sv
// Directed self-checking bench for ex_multdiv_unit; expected values are hand-computed constants.
module tb_ex_multdiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic        hilo_rd;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        stall_req;
  logic        done;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  ex_multdiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .hilo_rd   (hilo_rd),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issues one operation and checks latency, busy length, done width, HI/LO stability and result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int k;
    int busy_n;
    bit seen;
    logic [31:0] prev_hi;
    @(negedge clk);
    prev_hi = hi_out;
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    k = 0; busy_n = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      if (busy) busy_n++;
      if (k == 16) check({tag, " hi_stable"}, {32'd0, hi_out}, {32'd0, prev_hi});
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check({tag, " latency"}, 64'(k), 64'd33);
    check({tag, " busy_cycles"}, 64'(busy_n), 64'd33);
    check({tag, " result"}, {hi_out, lo_out}, {exp_hi, exp_lo});
    @(negedge clk);
    check({tag, " done_width"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; rs_val = 32'd0; rt_val = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; hilo_rd = 1'b0;
    #1;
    check("reset_state", {hi_out, lo_out}, 64'd0);
    check("reset_flags", {61'd0, busy, done, stall_req}, 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    run_op("mult_7_m3",   OP_MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("mult_min",    OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_min_m1",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_100_7",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);

    // Divide by zero: result on the very next edge, never busy.
    @(negedge clk);
    op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd0; start = 1'b1;
    #1;
    check("div0_busy_pre", {63'd0, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("div0_result", {hi_out, lo_out}, {32'd100, 32'hFFFF_FFFF});
    check("div0_done", {62'd0, done, busy}, 64'd2);
    @(negedge clk);
    check("div0_done_width", {62'd0, done, busy}, 64'd0);

    // hilo_rd from cycle 5 of a MULT; a stray mthi while busy must be ignored.
    @(negedge clk);
    op = OP_MULT; rs_val = 32'd6; rt_val = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 60 && busy; c++) begin
      if (c == 5) hilo_rd = 1'b1;
      if (c == 10) begin mthi = 1'b1; rs_val = 32'hDEAD_BEEF; end
      if (c == 11) mthi = 1'b0;
      #1;
      if (c == 6) check("stall_hilo_rd", {63'd0, stall_req}, 64'd1);
      if (c == 4) check("stall_no_req", {63'd0, stall_req}, 64'd0);
      @(negedge clk);
    end
    #1;
    check("stall_idle_hilo_rd", {62'd0, busy, stall_req}, 64'd0);
    check("ignored_mthi", {hi_out, lo_out}, {32'd0, 32'd30});
    hilo_rd = 1'b0;

    // Reset at cycle 20 of a DIV aborts with no write and no done.
    @(negedge clk);
    op = OP_DIV; rs_val = 32'd1000; rt_val = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_outputs", {hi_out, lo_out}, 64'd0);
    check("abort_flags", {61'd0, busy, done, stall_req}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", {63'd0, done}, 64'd0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("release_idle", {61'd0, busy, done, stall_req}, 64'd0);
    run_op("multu_3_4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    // Moves in IDLE.
    @(negedge clk);
    mthi = 1'b1; rs_val = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi", {hi_out, lo_out}, {32'h1234_5678, 32'd12});
    mtlo = 1'b1; rs_val = 32'hCAFE_F00D;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo", {hi_out, lo_out}, {32'h1234_5678, 32'hCAFE_F00D});

    // mthi together with start: start wins, HI comes only from the operation.
    mthi = 1'b1;
    run_op("mthi_with_start", OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
